// File: rtl/lsu_byte_serial.sv
// ---------------------------------------------------------------------------
// lsu_byte_serial
//
// Load/store unit that sits between the memory stage of the datapath and a
// byte-wide data memory. Each accepted request is broken into 1, 2 or 4
// single-byte accesses in little-endian order. Loads are assembled byte by
// byte and then sign- or zero-extended according to func3. Because every
// access is a single byte, a misaligned address needs no special treatment.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   When defined, an extra output err is added. A misaligned halfword or word
//   request is then rejected without touching memory, and err is raised in
//   its response cycle.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-low reset
//   req_*        request channel from the core (valid/ready)
//   resp_valid   one-cycle completion pulse
//   resp_rdata   extended load data (0 for stores and rejected requests)
//   err          (LSU_MISALIGN_TRAP_EN only) misalignment flag, valid with resp
//   busy         stall to the core, the inverse of req_ready
//   mem_*        byte-wide memory port; mem_rdata is combinational on mem_addr
//   state_dbg    current FSM state, for checkers and debug
//
// Request handshake: a request is accepted on a rising edge where
// req_valid & req_ready are both 1. req_ready is 1 only in IDLE and does not
// depend on req_valid. While the unit is busy the request inputs are ignored
// entirely; they are sampled only at the accepting edge.
// ---------------------------------------------------------------------------
module lsu_byte_serial #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              err,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Captured request
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        func3_q;
  logic              we_q;

  // Byte index inside the current operation and the load assembly register
  logic [1:0]        cnt_q;
  logic [XLEN-1:0]   asm_q;
  logic [XLEN-1:0]   asm_d;

  // Memory port values kept after ACCESS ends so the port does not glitch
  logic [ADDR_W-1:0] mem_addr_hold_q;
  logic [7:0]        mem_wdata_hold_q;

  logic              err_q;

  logic              handshake;
  logic              req_ok;
  logic              req_trap;
  logic [1:0]        last_idx;
  logic              last_byte;
  logic              in_access;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]        acc_wdata;

  // Legal requests: b/h/w for both directions, bu/hu for loads only.
  function automatic logic func3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3,
                                             input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (f3)
      3'b000:  r = {{(XLEN-8){v[7]}}, v[7:0]};
      3'b100:  r = {{(XLEN-8){1'b0}}, v[7:0]};
      3'b001:  r = {{(XLEN-16){v[15]}}, v[15:0]};
      3'b101:  r = {{(XLEN-16){1'b0}}, v[15:0]};
      3'b010:  r = v;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign handshake = req_valid & req_ready;
  assign in_access = (state_q == S_ACCESS);
  assign state_dbg = state_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_trap = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign err      = err_q & (state_q == S_RESP);
`else
  assign req_trap = 1'b0;
`endif

  assign req_ok = func3_legal(req_we, req_func3) & ~req_trap;

  // Index of the final byte: 0 for byte, 1 for halfword, 3 for word.
  always_comb begin
    last_idx = 2'd3;
    case (func3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  assign last_byte = (cnt_q == last_idx);

  // Byte k of the operation goes to addr_q + k; the sum wraps naturally
  // at ADDR_W bits.
  assign acc_addr  = addr_q + ADDR_W'(cnt_q);
  assign acc_wdata = wdata_q[{cnt_q, 3'b000} +: 8];

  assign mem_addr  = in_access ? acc_addr  : mem_addr_hold_q;
  assign mem_wdata = in_access ? acc_wdata : mem_wdata_hold_q;
  assign mem_we    = in_access & we_q;

  assign resp_valid = (state_q == S_RESP);

  // Assembly register with the byte arriving this cycle merged in, so the
  // final byte can feed the extension logic in the same cycle.
  always_comb begin
    asm_d = asm_q;
    asm_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          state_d = req_ok ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        if (last_byte) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q           <= '0;
      wdata_q          <= '0;
      func3_q          <= '0;
      we_q             <= 1'b0;
      cnt_q            <= '0;
      asm_q            <= '0;
      resp_rdata       <= '0;
      mem_addr_hold_q  <= '0;
      mem_wdata_hold_q <= '0;
      err_q            <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            func3_q <= req_func3;
            we_q    <= req_we;
            cnt_q   <= '0;
            asm_q   <= '0;
            err_q   <= req_trap;
            // Rejected requests skip ACCESS, so their zero response is
            // loaded here.
            if (!req_ok) begin
              resp_rdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          mem_addr_hold_q  <= acc_addr;
          mem_wdata_hold_q <= acc_wdata;
          if (!we_q) begin
            asm_q <= asm_d;
          end
          if (last_byte) begin
            resp_rdata <= we_q ? '0 : extend(func3_q, asm_d);
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_serial.sv
// ---------------------------------------------------------------------------
// tb_lsu_byte_serial
//
// Directed bench for lsu_byte_serial. A 256-byte memory model answers the
// byte port. The do_req driver issues one request, records the memory port
// cycle by cycle, and checks latency, the byte addresses, write strobes and
// data, and the response against an expected queue. Expected values are
// worked out by hand from the little-endian byte layout.
// ---------------------------------------------------------------------------
module tb_lsu_byte_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [1:0]  state_dbg;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Bench-side memory preload port
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [7:0]  tb_data;
  bit   [7:0]  mem [256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu_byte_serial #(.ADDR_W(8), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .err        (err),
`endif
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .state_dbg  (state_dbg)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // legal_rd: load result if the request is performed (0 for stores).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] legal_rd);
    int n;
    int lat;
    logic trap;
    logic [31:0] exp_rd;
    logic [7:0] tr_addr [4];
    logic       tr_we   [4];
    logic [7:0] tr_wd   [4];
    logic [7:0] ea;

    case (f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      3'b010:         n = 4;
      default:        n = 0;
    endcase
    if (we && f3[2]) n = 0;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
`endif
    if (trap) n = 0;
    exp_q.push_back((n == 0) ? 32'h0 : legal_rd);

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      if (lat < 4) begin
        tr_addr[lat] = mem_addr; tr_we[lat] = mem_we; tr_wd[lat] = mem_wdata;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat + 1), 32'(n + 1));
    for (int k = 0; k < n && k < lat && k < 4; k++) begin
      ea = a + 8'(k);
      check("mem_addr", {24'h0, tr_addr[k]}, {24'h0, ea});
      check("mem_we", {31'h0, tr_we[k]}, {31'h0, we});
      if (we) check("mem_wdata", {24'h0, tr_wd[k]}, {24'h0, wd[8*k +: 8]});
    end
    check("resp_valid", resp_valid, 1);
    exp_rd = exp_q.pop_front();
    check("resp_rdata", resp_rdata, exp_rd);
    check("mem_we_resp", mem_we, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("err_resp", err, trap);
`endif
    @(posedge clk); #1;
    check("resp_pulse", resp_valid, 0);
    check("rdata_hold", resp_rdata, exp_rd);
`ifdef LSU_MISALIGN_TRAP_EN
    check("err_after", err, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
    req_addr = 8'h00; req_wdata = 32'h0; tb_we = 1'b0; tb_addr = 8'h00; tb_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", {24'h0, mem_addr}, 0);
    check("rst_mem_wdata", {24'h0, mem_wdata}, 0);
    check("rst_state", {30'h0, state_dbg}, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("rst_err", err, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // lw from an aligned word
    poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
    do_req(1'b0, 3'b010, 8'h10, 32'h0, 32'h4433_2211);

    // sh then lh / lhu at an odd address
    do_req(1'b1, 3'b001, 8'h21, 32'hDEAD_BEEF, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
    check("sh_mem21", {24'h0, mem[8'h21]}, 32'hEF);
    check("sh_mem22", {24'h0, mem[8'h22]}, 32'hBE);
`endif
    do_req(1'b0, 3'b001, 8'h21, 32'h0, 32'hFFFF_BEEF);
    do_req(1'b0, 3'b101, 8'h21, 32'h0, 32'h0000_BEEF);

    // byte extension and sb
    poke(8'h05, 8'h80);
    do_req(1'b0, 3'b000, 8'h05, 32'h0, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 8'h05, 32'h0, 32'h0000_0080);
    do_req(1'b1, 3'b000, 8'h05, 32'h0000_007F, 32'h0);
    check("sb_mem05", {24'h0, mem[8'h05]}, 32'h7F);

    // address wrap across 0xFF -> 0x00
    poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03); poke(8'h01, 8'h04);
    do_req(1'b0, 3'b010, 8'hFE, 32'h0, 32'h0403_0201);

    // illegal requests: reserved func3 load, unsigned store
    do_req(1'b0, 3'b011, 8'h30, 32'h0, 32'h0);
    do_req(1'b1, 3'b100, 8'h30, 32'h0000_0055, 32'h0);
    check("illegal_no_write", {24'h0, mem[8'h30]}, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    poke(8'h02, 8'h34); poke(8'h03, 8'h12);
    do_req(1'b0, 3'b010, 8'h02, 32'h0, 32'h0);
    do_req(1'b0, 3'b001, 8'h02, 32'h0, 32'h0000_1234);
`endif

    // reset in the middle of a word store, with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010;
    req_addr = 8'h40; req_wdata = 32'hA1B2_C3D4;
    @(posedge clk); #1;
    req_addr = 8'h80; req_wdata = 32'h0;
    check("midop_k0_addr", {24'h0, mem_addr}, 32'h40);
    check("midop_k0_we", mem_we, 1);
    check("midop_busy", busy, 1);
    @(posedge clk); #1;
    check("midop_k1_addr", {24'h0, mem_addr}, 32'h41);
    check("midop_k1_wdata", {24'h0, mem_wdata}, 32'hC3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midop_rst_we", mem_we, 0);
    check("midop_rst_ready", req_ready, 1);
    check("midop_rst_resp", resp_valid, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midop_no_resp", resp_valid, 0);
    end
    check("midop_mem40", {24'h0, mem[8'h40]}, 32'hD4);
    check("midop_mem41", {24'h0, mem[8'h41]}, 32'hC3);
    check("midop_mem42", {24'h0, mem[8'h42]}, 32'h00);
    check("midop_mem43", {24'h0, mem[8'h43]}, 32'h00);

    // unit still works after the aborted store
    do_req(1'b0, 3'b001, 8'h40, 32'h0, 32'hFFFF_C3D4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
